// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store port (C)
// and the DMA/program-loader port (D). One owner at a time, round-robin on a
// tie, bounded burst while the other port waits, and registered read data
// returned per port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   c_req/d_req              request, held until all beats are done
//   c_we/d_we                1 = write beat, 0 = read beat
//   c_addr/d_addr            beat address
//   c_wdata/d_wdata          beat write data
//   c_gnt/d_gnt              grant (decoded from the state register)
//   c_rdata/d_rdata          registered data of the port's last read beat
//   c_rvalid/d_rvalid        one-cycle pulse when rdata is updated
//   c_stall                  c_req & ~c_gnt (combinational)
//   m_addr/m_wdata/m_we      memory request (combinational mux)
//   m_rdata                  memory combinational read data
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic              c_stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  // last-served encoding
  localparam logic LAST_C = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             beat_c, beat_d;

  // A beat executes on an edge where the owner is still requesting.
  assign beat_c  = (state == OWN_C) & c_req;
  assign beat_d  = (state == OWN_D) & d_req;
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  assign c_gnt   = (state == OWN_C);
  assign d_gnt   = (state == OWN_D);
  assign c_stall = c_req & ~c_gnt;

  // State, last-served and burst counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= LAST_D;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, release rules and memory mux.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    m_addr    = '0;
    m_wdata   = '0;
    m_we      = 1'b0;

    case (state)
      IDLE: begin
        if (c_req && d_req) begin
          state_nxt = (last == LAST_D) ? OWN_C : OWN_D;
        end else if (c_req) begin
          state_nxt = OWN_C;
        end else if (d_req) begin
          state_nxt = OWN_D;
        end
      end
      OWN_C: begin
        if (!c_req) begin
          state_nxt = d_req ? OWN_D : IDLE;
          last_nxt  = LAST_C;
        end else begin
          cnt_nxt = cnt_inc;
          if (d_req && (cnt_inc == CNT_MAX)) begin
            state_nxt = OWN_D;
            last_nxt  = LAST_C;
          end
        end
      end
      OWN_D: begin
        if (!d_req) begin
          state_nxt = c_req ? OWN_C : IDLE;
          last_nxt  = LAST_D;
        end else begin
          cnt_nxt = cnt_inc;
          if (c_req && (cnt_inc == CNT_MAX)) begin
            state_nxt = OWN_C;
            last_nxt  = LAST_D;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Every ownership change starts a fresh burst.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end

    // Write enable is gated by rst so a mid-transfer reset cannot corrupt memory.
    if (beat_c) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_we    = c_we & ~rst;
    end else if (beat_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we & ~rst;
    end
  end

  // Per-port read data capture and rvalid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rdata  <= '0;
      d_rdata  <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      c_rvalid <= beat_c & ~c_we;
      d_rvalid <= beat_d & ~d_we;
      if (beat_c && !c_we) begin
        c_rdata <= m_rdata;
      end
      if (beat_d && !d_we) begin
        d_rdata <= m_rdata;
      end
    end
  end

endmodule
